// File: rtl/psk4_demodulator.sv
// 4-phase square-wave carrier demodulator: times each rising carrier edge against a
// local period counter, maps it to the nearest quarter period and confirms the symbol.
module psk4_demodulator #(
    parameter int FREQ_DIV  = 128,
    parameter int PHASE_OFS = 1,
    parameter int CONFIRM   = 2,
    parameter int TIMEOUT   = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din,
    output logic [1:0] dout,
    output logic       dout_valid,
    output logic       locked
);

    localparam int CNT_W = $clog2(FREQ_DIV);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int RUN_W = 4;

    localparam logic [CNT_W-1:0] OFS_C     = CNT_W'(PHASE_OFS % FREQ_DIV);
    localparam logic [CNT_W-1:0] EIGHTH_C  = CNT_W'(FREQ_DIV / 8);
    localparam logic [RUN_W-1:0] CONFIRM_C = RUN_W'(CONFIRM);
    localparam logic [TMR_W-1:0] TIMEOUT_C = TMR_W'(TIMEOUT);

    typedef enum logic {
        ST_ACQUIRE,
        ST_LOCKED
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_din_d;
    logic [TMR_W-1:0]  r_timer;
    logic [RUN_W-1:0]  r_run;
    logic [1:0]        r_last_sym;
    logic [1:0]        r_dout;
    logic              r_dout_valid;
    logic              r_locked;

    state_t            w_state_next;
    logic              w_rise;
    logic [CNT_W-1:0]  w_q;
    logic [1:0]        w_sym;
    logic [RUN_W-1:0]  w_run_next;
    logic              w_timeout;
    logic [RUN_W-1:0]  w_run_upd;
    logic [1:0]        w_last_upd;
    logic [1:0]        w_dout_next;
    logic              w_valid_next;
    logic              w_locked_next;

    assign w_rise = din & ~r_din_d;

    // Shifting by an eighth period turns "nearest quarter" into a plain truncation.
    assign w_q   = r_cnt - OFS_C + EIGHTH_C;
    assign w_sym = w_q[CNT_W-1 -: 2];

    assign w_run_next = (w_sym != r_last_sym) ? RUN_W'(1) :
                        (r_run >= CONFIRM_C)  ? CONFIRM_C : r_run + RUN_W'(1);

    assign w_timeout = ~w_rise && (r_timer == TIMEOUT_C - TMR_W'(1));

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a
        // signal unassigned, which would otherwise infer a latch.
        w_state_next  = r_state;
        w_dout_next   = r_dout;
        w_valid_next  = 1'b0;
        w_locked_next = r_locked;
        w_run_upd     = r_run;
        w_last_upd    = r_last_sym;

        if (w_rise) begin
            w_run_upd  = w_run_next;
            w_last_upd = w_sym;
        end

        case (r_state)
            ST_ACQUIRE: begin
                if (w_rise && w_run_next == CONFIRM_C) begin
                    w_dout_next   = w_sym;
                    w_valid_next  = 1'b1;
                    w_locked_next = 1'b1;
                    w_state_next  = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (w_rise) begin
                    if (w_sym == r_dout) begin
                        w_valid_next = 1'b1;
                    end else if (w_run_next == CONFIRM_C) begin
                        w_dout_next  = w_sym;
                        w_valid_next = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_next  = ST_ACQUIRE;
                    w_locked_next = 1'b0;
                    w_run_upd     = '0;
                end
            end
            default: w_state_next = ST_ACQUIRE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values,
        // independent of statement order.
        if (!reset) begin
            r_state      <= ST_ACQUIRE;
            r_cnt        <= '0;
            r_din_d      <= 1'b0;
            r_timer      <= '0;
            r_run        <= '0;
            r_last_sym   <= 2'b00;
            r_dout       <= 2'b00;
            r_dout_valid <= 1'b0;
            r_locked     <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= r_cnt + CNT_W'(1);
            r_din_d      <= din;
            r_run        <= w_run_upd;
            r_last_sym   <= w_last_upd;
            r_dout       <= w_dout_next;
            r_dout_valid <= w_valid_next;
            r_locked     <= w_locked_next;
            if (w_rise) begin
                r_timer <= '0;
            end else if (r_timer != TIMEOUT_C) begin
                r_timer <= r_timer + TMR_W'(1);
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign locked     = r_locked;

endmodule
